bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 191 +++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed 6-digit HH.MM.SS 7-segment scanner
//
// Purpose: scans packed-BCD hour/minute/second words onto a 6-digit
// multiplexed 7-segment display, one digit per SCAN_DIV clocks, with a
// one-cycle blank between digits, leading hours-zero suppression, and a
// once-per-frame input snapshot so a frame never mixes carry states.
//
// Parameters:
//   SCAN_DIV       clocks each digit slot lasts (>= 2), last one is blank
//   SEG_ACTIVE_LOW 1: seg/dp driven low to light
//   AN_ACTIVE_LOW  1: an driven low to select
//   BLINK_FRAMES   frames per blink half-period (BCD_SCAN_BLINK_EN only)
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   hour_bcd       [7:4] tens, [3:0] ones
//   min_bcd        packed BCD minutes
//   sec_bcd        packed BCD seconds
//   blink_mask     {hours, minutes, seconds} blink enables (BCD_SCAN_BLINK_EN only)
//   an             digit select, bit0 = seconds ones .. bit5 = hours tens
//   seg            {g,f,e,d,c,b,a}
//   dp             decimal point
//
// Optional feature macro: BCD_SCAN_BLINK_EN (adds blink_mask and BLINK_FRAMES).

module bcd_scan_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
`ifdef BCD_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
`ifdef BCD_SCAN_BLINK_EN
    input  logic [2:0] blink_mask,
`endif
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW  ? 6'h3F : 6'h00;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      snap_q, snap_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             div_last;
    logic             frame_end;
    logic [3:0]       nibble;
    logic             blank;
    logic [5:0]       an_log;
    logic [6:0]       seg_log;
    logic             dp_log;

`ifdef BCD_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic [2:0]      mask_q, mask_d;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;   // non-BCD nibble shows a dash
        endcase
    endfunction

    always_comb begin
        div_last  = (div_cnt_q == DIV_LAST);
        frame_end = div_last && (idx_q == 3'd5);

        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_last) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // Snapshot on the dead cycle before digit 0 so the new frame is coherent.
        snap_d = frame_end ? {hour_bcd, min_bcd, sec_bcd} : snap_q;

        case (idx_q)
            3'd0:    nibble = snap_q[3:0];
            3'd1:    nibble = snap_q[7:4];
            3'd2:    nibble = snap_q[11:8];
            3'd3:    nibble = snap_q[15:12];
            3'd4:    nibble = snap_q[19:16];
            3'd5:    nibble = snap_q[23:20];
            default: nibble = 4'd0;
        endcase

        // Hours tens zero is blanked but still selected to keep timing uniform.
        blank = (idx_q == 3'd5) && (nibble == 4'd0);

`ifdef BCD_SCAN_BLINK_EN
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        mask_d        = frame_end ? blink_mask : mask_q;
        if (frame_end) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        // idx[2:1] maps digit pairs to seconds/minutes/hours.
        if (blink_phase_q && mask_q[idx_q[2:1]]) begin
            blank = 1'b1;
        end
`endif

        an_log  = 6'b000001 << idx_q;
        seg_log = blank ? 7'h00 : decode(nibble);
        dp_log  = ((idx_q == 3'd2) || (idx_q == 3'd4)) && !blank;

        // Anti-ghosting: one fully dark cycle at every digit change.
        if (div_last) begin
            an_log  = 6'h00;
            seg_log = 7'h00;
            dp_log  = 1'b0;
        end

        an_d  = AN_ACTIVE_LOW  ? ~an_log  : an_log;
        seg_d = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_log  : dp_log;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            snap_q    <= 24'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

`ifdef BCD_SCAN_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            mask_q        <= 3'b000;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            mask_q        <= mask_d;
        end
    end
`endif

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - randomized self-checking bench for bcd_scan_display

module tb_bcd_scan_display;

    localparam int D     = 4;
    localparam int FRAME = 6 * D;
    localparam int BF    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [2:0] blink_mask;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;
    logic [23:0] msnap = 24'd0;
    logic [2:0]  mmask = 3'd0;
    logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    bcd_scan_display #(
        .SCAN_DIV(D),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
`ifdef BCD_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .hour_bcd(hour_bcd),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
`ifdef BCD_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %h, expected %h", tag, k, got, exp);
        end
    endtask

    // Pins after edge kk (kk = edges since reset release): slot = kk/D,
    // last cycle of each slot dark; frame f shows the inputs present at
    // the final edge of frame f-1 (zero for the first frame).
    function automatic void expect_pins(input int kk, input logic [23:0] s, input logic [2:0] m,
                                        output logic [5:0] a, output logic [6:0] sg, output logic dpo);
        int         div, id, fr;
        logic [3:0] nib;
        logic [6:0] lg;
        logic [5:0] sel;
        bit         blank, dpl, phase;
        div = kk % D;
        id  = (kk / D) % 6;
        fr  = kk / FRAME;
        if (div == D - 1) begin
            a = 6'h3F; sg = 7'h7F; dpo = 1'b1;
            return;
        end
        nib = s[id*4 +: 4];
        lg  = (nib <= 4'd9) ? seg_tab[nib] : 7'h40;
        blank = (id == 5) && (nib == 4'd0);
`ifdef BCD_SCAN_BLINK_EN
        phase = ((fr / BF) % 2) == 1;
`else
        phase = 1'b0;
`endif
        if (phase && m[id/2]) blank = 1'b1;
        dpl = ((id == 2) || (id == 4)) && !blank;
        sel = 6'b000001 << id;
        a   = ~sel;
        sg  = blank ? 7'h7F : ~lg;
        dpo = ~dpl;
    endfunction

    task automatic step();
        logic [5:0] ea;
        logic [6:0] es;
        logic       ed;
        @(posedge clk);
        #1;
        if (reset) begin
            check_eq("reset_an", 32'(an), 32'h3F);
            check_eq("reset_seg", 32'(seg), 32'h7F);
            check_eq("reset_dp", 32'(dp), 32'h1);
            k     = 0;
            msnap = 24'd0;
            mmask = 3'd0;
        end else begin
            expect_pins(k, msnap, mmask, ea, es, ed);
            check_eq("an", 32'(an), 32'(ea));
            check_eq("seg", 32'(seg), 32'(es));
            check_eq("dp", 32'(dp), 32'(ed));
            if (k % FRAME == FRAME - 1) begin
                msnap = {hour_bcd, min_bcd, sec_bcd};
                mmask = blink_mask;
            end
            k++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] rnib();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        reset      = 1'b1;
        hour_bcd   = 8'h00;
        min_bcd    = 8'h00;
        sec_bcd    = 8'h00;
        blink_mask = 3'b000;
        run(3);
        reset = 1'b0;

        // Full frame 12.34.56, two frames.
        hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
        run(2 * FRAME);

        // Leading zero and invalid nibble.
        hour_bcd = 8'h07; sec_bcd = 8'h5C;
        run(2 * FRAME);

        // Snapshot coherence: 59 -> 00 at idx 2.
        sec_bcd = 8'h59;
        while (k % FRAME != 0) step();
        run(FRAME);
        run(2 * D);
        sec_bcd = 8'h00;
        run(2 * FRAME);

        // Reset in the middle of a frame at idx 3.
        hour_bcd = 8'h23; min_bcd = 8'h45;
        while ((k / D) % 6 != 3) step();
        run(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(2 * FRAME);

        // Blink on minutes.
        blink_mask = 3'b010;
        run(6 * FRAME);

        // Randomized inputs changing at arbitrary cycles.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                hour_bcd   = {rnib(), rnib()};
                min_bcd    = {rnib(), rnib()};
                sec_bcd    = {rnib(), rnib()};
                blink_mask = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
